// File: rtl/multicycle_core.sv
// multicycle_core: parametrised multicycle MIPS-subset core.
// Instructions: add, sub, and, or, slt, lw, sw, beq, addi, j.
// Instruction and data memories are synchronous with a 1-cycle read latency.
// Optional feature macro: MULTICYCLE_CORE_STEP_EN. When it is defined, a 'step'
// input gates the FETCH state. When it is undefined, there is no step port.

module multicycle_core #(
  parameter int N    = 8,
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef MULTICYCLE_CORE_STEP_EN
  input  logic                    step,
`endif
  output logic [PC_W-1:0]         imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic [N-1:0]            dmem_addr,
  output logic [N-1:0]            dmem_wdata,
  output logic                    dmem_we,
  input  logic [N-1:0]            dmem_rdata,
  output logic [PC_W-1:0]         pc,
  output logic [3:0]              state,
  output logic                    instr_done,
  output logic                    illegal,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [N-1:0]            dbg_data
);

  localparam int              RW     = $clog2(NREG);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALUWB    = 4'd3,
    S_MEMADR   = 4'd4,
    S_MEMREAD  = 4'd5,
    S_MEMWB    = 4'd6,
    S_MEMWRITE = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [N-1:0]    a_q, b_q, aluout_q;
  logic [N-1:0]    regs_q [NREG];

  logic [5:0]      in_op, in_fn;
  logic            in_legal;
  state_e          dec_next;
  logic [RW-1:0]   rs_in, rt_in;
  logic [31:0]     imm_ext;
  logic [N-1:0]    simm;
  logic [PC_W-1:0] br_off, pc_inc;
  logic [N-1:0]    alu_res;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [N-1:0]    rf_wdata;
  logic            fetch_go;
  logic            ir_unused;

`ifdef MULTICYCLE_CORE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // The word arriving from instruction memory is decoded while it is latched into IR.
  assign in_op = imem_rdata[31:26];
  assign in_fn = imem_rdata[5:0];
  assign rs_in = imem_rdata[21 +: RW];
  assign rt_in = imem_rdata[16 +: RW];

  // A single 32-bit sign extension serves both the N-bit immediate and the
  // PC_W-bit branch offset. For PC_W <= 16, the low bits are exactly IR[PC_W-1:0].
  assign imm_ext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign simm      = imm_ext[N-1:0];
  assign br_off    = imm_ext[PC_W-1:0];
  assign pc_inc    = pc_q + PC_ONE;
  assign ir_unused = ^{ir_q, imm_ext};

  // Classify the incoming instruction and choose the state that follows DECODE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    in_legal = 1'b1;
    dec_next = S_FETCH;
    case (in_op)
      OP_RTYPE: begin
        dec_next = S_EXEC;
        in_legal = (in_fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
      end
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_ADDI:      dec_next = S_ADDIEX;
      OP_J:         dec_next = S_JUMP;
      default:      in_legal = 1'b0;
    endcase
    if (!in_legal) dec_next = S_FETCH;
  end

  // The ALU computes the R-type operation in EXEC and A + SignImm otherwise.
  always_comb begin
    alu_res = a_q + simm;
    if (state_q == S_EXEC) begin
      case (ir_q[5:0])
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // Register-file write port: active only in the three write-back states.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ir_q[16 +: RW];
    rf_wdata = aluout_q;
    case (state_q)
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = ir_q[11 +: RW];
      end
      S_ADDIWB: rf_we = 1'b1;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = dmem_rdata;
      end
      default: ;
    endcase
  end

  // Register file. Writes to register 0 are dropped, so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is built from flops, not a RAM macro, so
      // clearing every entry on reset is legal here and required.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Main FSM: sequences each instruction and updates PC on its last cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (fetch_go) state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= imem_rdata;
          a_q     <= regs_q[rs_in];
          b_q     <= regs_q[rt_in];
          state_q <= dec_next;
          if (!in_legal) pc_q <= pc_inc;
        end
        S_EXEC: begin
          aluout_q <= alu_res;
          state_q  <= S_ALUWB;
        end
        S_MEMADR: begin
          aluout_q <= alu_res;
          state_q  <= (ir_q[31:26] == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: state_q <= S_MEMWB;
        S_ADDIEX: begin
          aluout_q <= alu_res;
          state_q  <= S_ADDIWB;
        end
        S_BRANCH: begin
          pc_q    <= (a_q == b_q) ? pc_inc + br_off : pc_inc;
          state_q <= S_FETCH;
        end
        S_JUMP: begin
          pc_q    <= ir_q[PC_W-1:0];
          state_q <= S_FETCH;
        end
        S_ALUWB, S_MEMWB, S_MEMWRITE, S_ADDIWB: begin
          pc_q    <= pc_inc;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;
  assign dmem_we    = (state_q == S_MEMWRITE) & ~rst;
  assign illegal    = ~rst & (state_q == S_DECODE) & ~in_legal;
  assign instr_done = ~rst & ((state_q inside {S_ALUWB, S_MEMWB, S_MEMWRITE, S_ADDIWB,
                                               S_BRANCH, S_JUMP}) |
                              ((state_q == S_DECODE) & ~in_legal));
  assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and random programs for multicycle_core.
// An instruction-level reference model predicts registers, PC, stores and latency.

module tb_multicycle_core;

  localparam int  N    = 8;
  localparam int  PC_W = 8;
  localparam int  NREG = 8;
  localparam time HALF = 20;

  logic        clk = 1'b0;
  logic        rst;
`ifdef MULTICYCLE_CORE_STEP_EN
  logic        step;
`endif
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [7:0]  pc;
  logic [3:0]  state;
  logic        instr_done, illegal;
  logic [2:0]  dbg_sel;
  logic [7:0]  dbg_data;

  multicycle_core #(.N(N), .PC_W(PC_W), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MULTICYCLE_CORE_STEP_EN
    .step       (step),
`endif
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #HALF clk = ~clk;

  // Synchronous memories with 1-cycle read latency.
  logic [31:0] imem [256];
  logic [7:0]  dmem [256];
  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Architectural reference state.
  logic [7:0] m_regs [8];
  logic [7:0] m_dmem [256];
  logic [7:0] m_pc;
  int         elapsed;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k <= 6) begin
      w[31:26] = 6'h00;
      case ($urandom_range(0, 4))
        0:       w[5:0] = 6'h20;
        1:       w[5:0] = 6'h22;
        2:       w[5:0] = 6'h24;
        3:       w[5:0] = 6'h25;
        default: w[5:0] = 6'h2A;
      endcase
    end
    else if (k <= 8)  w[31:26] = 6'h23;
    else if (k <= 10) w[31:26] = 6'h2B;
    else if (k <= 12) w[31:26] = 6'h04;
    else if (k <= 16) w[31:26] = 6'h08;
    else if (k == 17) w[31:26] = 6'h02;
    else if (k == 18) w[31:26] = 6'h3F;
    else begin
      w[31:26] = 6'h00;
      w[5:0]   = 6'h21;
    end
    return w;
  endfunction

  task automatic set_reg(input logic [2:0] idx, input logic [7:0] v);
    if (idx != 3'd0) m_regs[idx] = v;
  endtask

  // Execute one instruction at ISA level. Return its latency, whether it is
  // illegal, and any store it performs.
  task automatic model_exec(input logic [31:0] ins, output int lat, output int ill,
                            output int wr, output logic [7:0] wa, output logic [7:0] wd);
    logic [5:0] op, fn;
    logic [2:0] rs, rt, rd;
    logic [7:0] a, b, imm8, res, addr;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[23:21]; rt = ins[18:16]; rd = ins[13:11];
    a = m_regs[rs]; b = m_regs[rt]; imm8 = ins[7:0];
    addr = a + imm8;
    lat = 2; ill = 0; wr = 0; wa = '0; wd = '0; res = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2A:   res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
          default: ill = 1;
        endcase
        if (ill == 0) begin set_reg(rd, res); lat = 4; m_pc = m_pc + 8'd1; end
      end
      6'h23: begin set_reg(rt, m_dmem[addr]); lat = 5; m_pc = m_pc + 8'd1; end
      6'h2B: begin
        m_dmem[addr] = b; wr = 1; wa = addr; wd = b; lat = 4; m_pc = m_pc + 8'd1;
      end
      6'h04: begin lat = 3; m_pc = (a == b) ? m_pc + 8'd1 + imm8 : m_pc + 8'd1; end
      6'h08: begin set_reg(rt, a + imm8); lat = 4; m_pc = m_pc + 8'd1; end
      6'h02: begin lat = 3; m_pc = ins[7:0]; end
      default: ill = 1;
    endcase
    if (ill != 0) m_pc = m_pc + 8'd1;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("reg%0d", i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  task automatic check_const(input int idx, input logic [7:0] v);
    dbg_sel = 3'(idx);
    #1;
    check($sformatf("spec_reg%0d", idx), 32'(dbg_data), 32'(v));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = '0;
    elapsed = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
  endtask

  // Call in FETCH. Run one instruction and return the cycle (counted from
  // reset release) in which instr_done was seen.
  task automatic run_one(output int done_at);
    logic [31:0] ins;
    int lat, ill, wr, n, we_cnt, ill_cnt;
    logic [7:0] wa, wd, got_a, got_d;
    ins = imem[m_pc];
    model_exec(ins, lat, ill, wr, wa, wd);
    n = 1; we_cnt = 0; ill_cnt = 0; got_a = '0; got_d = '0;
    check("fetch_state", 32'(state), 32'd0);
    while (instr_done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
      if (dmem_we === 1'b1) begin we_cnt++; got_a = dmem_addr; got_d = dmem_wdata; end
      if (illegal === 1'b1) ill_cnt++;
    end
    done_at = elapsed + n;
    elapsed = done_at;
    check("latency", n, lat);
    check("dmem_we_cycles", we_cnt, wr);
    check("illegal_pulses", ill_cnt, ill);
    if (wr != 0) begin
      check("store_addr", 32'(got_a), 32'(wa));
      check("store_data", 32'(got_d), 32'(wd));
    end
    @(negedge clk);
    check("pc_next", 32'(pc), 32'(m_pc));
    check("state_next", 32'(state), 32'd0);
    check_regs();
  endtask

  initial begin
    int d, n;
    rst = 1'b1;
    dbg_sel = '0;
`ifdef MULTICYCLE_CORE_STEP_EN
    step = 1'b1;
`endif
    for (int i = 0; i < 256; i++) begin
      imem[i]   = 32'hFC00_0000;
      dmem[i]   = 8'($urandom);
      m_dmem[i] = dmem[i];
    end

    // Program A: arithmetic, store/load, R0 write, jump wrap-around.
    imem[0]   = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1]   = enc_i(6'h08, 5'd2, 5'd0, 16'd3);
    imem[2]   = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    imem[3]   = enc_r(6'h22, 5'd4, 5'd1, 5'd2);
    imem[4]   = enc_r(6'h2A, 5'd5, 5'd2, 5'd1);
    imem[5]   = enc_i(6'h2B, 5'd3, 5'd0, 16'h0010);
    imem[6]   = enc_i(6'h23, 5'd6, 5'd0, 16'h0010);
    imem[7]   = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[8]   = enc_j(26'h00000FF);
    imem[255] = enc_i(6'h08, 5'd7, 5'd0, 16'd1);

    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    check_regs();

    for (int k = 0; k < 5; k++) begin
      run_one(d);
      check("done_cycle", d, 4 * (k + 1));
    end
    check_const(3, 8'd8);
    check_const(4, 8'd2);
    check_const(5, 8'd1);
    run_one(d);
    check("sw_mem", 32'(dmem[8'h10]), 32'd8);
    run_one(d);
    check("lw_done_cycle", d, 29);
    check_const(6, 8'd8);
    run_one(d);
    check_const(0, 8'd0);
    run_one(d);
    check("jump_pc", 32'(pc), 32'hFF);
    run_one(d);
    check("wrap_pc", 32'(pc), 32'h00);

    // Program B: illegal opcode at pc=2, then a self-loop beq at pc=5.
    imem[0] = enc_i(6'h08, 5'd7, 5'd0, 16'd9);
    imem[1] = enc_i(6'h2B, 5'd7, 5'd0, 16'h0020);
    imem[2] = 32'hFC00_0000;
    imem[3] = enc_j(26'd5);
    imem[5] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    run_one(d);
    run_one(d);
    run_one(d);
    check("illegal_pc", 32'(pc), 32'd3);
    run_one(d);
    for (int k = 0; k < 3; k++) begin
      run_one(d);
      check("beq_loop_pc", 32'(pc), 32'd5);
    end

    // Program C: reset that lands in MEMWRITE aborts the store.
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'h0055);
    imem[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'h0030);
    do_reset();
    run_one(d);
    n = 0;
    while (state !== 4'd7 && n < 10) begin @(negedge clk); n++; end
    check("reach_memwrite", 32'(state), 32'd7);
    rst = 1'b1;
    #1;
    check("we_under_rst", 32'(dmem_we), 32'd0);
    check("done_under_rst", 32'(instr_done), 32'd0);
    @(negedge clk);
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    elapsed = 0;
    check("abort_mem", 32'(dmem[8'h30]), 32'(m_dmem[8'h30]));

`ifdef MULTICYCLE_CORE_STEP_EN
    // Single-step: FETCH holds while step=0, and one pulse runs one instruction.
    step = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("step_hold", 32'(state), 32'd0);
    end
    begin
      int lat, ill, wr;
      logic [7:0] wa, wd;
      model_exec(imem[m_pc], lat, ill, wr, wa, wd);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_decode", 32'(state), 32'd1);
    n = 0;
    while (instr_done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("step_done", 32'(instr_done), 32'd1);
    @(negedge clk);
    check("step_pc", 32'(pc), 32'(m_pc));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("step_idle", 32'(state), 32'd0);
    end
    check_regs();
    step = 1'b1;
`endif

    // Random program checked against the ISA-level model.
    for (int i = 0; i < 256; i++) begin
      imem[i]   = rand_instr();
      dmem[i]   = 8'($urandom);
      m_dmem[i] = dmem[i];
    end
    do_reset();
    for (int k = 0; k < 300; k++) run_one(d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
